// File: rtl/truth_table_pkg.sv
// truth_table_pkg: shared FSM state type and sweep constants for the truth-table sequencer
package truth_table_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
  localparam logic [1:0] VEC_LAST = 2'b11;
endpackage

// File: rtl/truth_table_sequencer_if.sv
// truth_table_sequencer_if: run request, applied vector and sweep result between bench and sequencer
// Optional fault input present when TRUTH_TABLE_FAULT_INJECT_EN is defined.
interface truth_table_sequencer_if;
  logic start;
  logic [1:0] vec;
  logic y;
  logic busy;
  logic done;
  logic pass;
  logic [1:0] fail_idx;
`ifdef TRUTH_TABLE_FAULT_INJECT_EN
  logic fault;
  modport master(output start, fault, input vec, y, busy, done, pass, fail_idx);
  modport slave(input start, fault, output vec, y, busy, done, pass, fail_idx);
`else
  modport master(output start, input vec, y, busy, done, pass, fail_idx);
  modport slave(input start, output vec, y, busy, done, pass, fail_idx);
`endif
endinterface

// File: rtl/and2.sv
// and2: two-input AND gate under test
module and2 (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  assign o_y = i_a & i_b;
endmodule

// File: rtl/truth_table_sequencer_step_timer.sv
// step_timer: down-counter loaded with STEP_CYCLES-1, flags zero to end a vector's hold time
module step_timer #(
  parameter int STEP_CYCLES = 100000000,
  localparam int W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= W'(STEP_CYCLES - 1);
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - W'(1);
  end
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps vectors 00..11 through an and2 gate and reports pass/first failing vector
// Define TRUTH_TABLE_FAULT_INJECT_EN to add a fault input that inverts the observed gate output.
module truth_table_sequencer
  import truth_table_pkg::*;
#(
  parameter int STEP_CYCLES = 100000000
) (
  input logic clk,
  input logic rst_n,
  truth_table_sequencer_if.slave bus
);
  state_t r_state;
  logic [1:0] r_sync, r_vec, r_fail_idx;
  logic r_prev, r_err, r_busy, r_done, r_pass;
  logic w_rise, w_zero, w_load, w_dec, w_gate, w_mis;
  and2 u_and2 (.i_a(r_vec[0]), .i_b(r_vec[1]), .o_y(w_gate));
`ifdef TRUTH_TABLE_FAULT_INJECT_EN
  assign bus.y = w_gate ^ bus.fault;
`else
  assign bus.y = w_gate;
`endif
  assign w_rise = r_sync[1] & ~r_prev;
  assign w_mis  = bus.y != (r_vec[0] & r_vec[1]);
  assign w_dec  = (r_state == APPLY);
  assign w_load = ((r_state == IDLE || r_state == DONE) && w_rise) || (r_state == CHECK && r_vec != VEC_LAST);
  step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk(clk), .rst_n(rst_n), .i_load(w_load), .i_dec(w_dec), .o_zero(w_zero)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sync <= '0;
      r_prev <= 1'b0;
      r_vec <= '0;
      r_fail_idx <= '0;
      r_err <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], bus.start};
      r_prev <= r_sync[1];
      case (r_state)
        IDLE, DONE: if (w_rise) begin
          r_state <= APPLY;
          r_vec <= '0;
          r_err <= 1'b0;
          r_fail_idx <= '0;
          r_done <= 1'b0;
          r_pass <= 1'b0;
          r_busy <= 1'b1;
        end
        APPLY: if (w_zero) r_state <= CHECK;
        CHECK: begin
          if (w_mis && !r_err) begin
            r_err <= 1'b1;
            r_fail_idx <= r_vec;
          end
          if (r_vec == VEC_LAST) begin
            r_state <= DONE;
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= ~(r_err | w_mis);
          end else begin
            r_state <= APPLY;
            r_vec <= r_vec + 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.vec = r_vec;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.pass = r_pass;
  assign bus.fail_idx = r_fail_idx;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: directed sweeps with STEP_CYCLES=4 against hand-derived cycle timing
module tb_truth_table_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;
  truth_table_sequencer_if bus();
  truth_table_sequencer #(.STEP_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
`ifdef TRUTH_TABLE_FAULT_INJECT_EN
  logic [1:0] fmode = 2'd0;
  assign bus.fault = (fmode == 2'd1) || (fmode == 2'd2 && bus.vec == 2'b10);
`endif
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // i counts edges after the one that first samples start; sweep enters APPLY at i=2, done at i=22
  task automatic sweep(input int re_at, input bit prev_done, input bit exp_pass, input logic [1:0] exp_fi);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 22; i++) begin
      @(posedge clk); #1;
      if (i == 3) bus.start = 1'b0;
      if (re_at != 0 && i == re_at) bus.start = 1'b1;
      if (re_at != 0 && i == re_at + 3) bus.start = 1'b0;
      if (i >= 2) chk("vec", bus.vec, (i >= 22) ? 3 : (i - 2) / 5);
      if (i == 2) chk("fail_idx_clr", bus.fail_idx, 0);
      chk("busy", bus.busy, (i >= 2 && i < 22) ? 1 : 0);
      chk("done", bus.done, (i >= 22 || (i < 2 && prev_done)) ? 1 : 0);
    end
    chk("pass", bus.pass, exp_pass);
    chk("fail_idx", bus.fail_idx, exp_fi);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vec", bus.vec, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pass", bus.pass, 0);
    chk("rst_fail_idx", bus.fail_idx, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("idle_done", bus.done, 0);
    sweep(0, 1'b0, 1'b1, 2'b00);
    sweep(8, 1'b1, 1'b1, 2'b00);
    @(posedge clk); #1 bus.start = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("abort_vec_pre", bus.vec, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_vec", bus.vec, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_pass", bus.pass, 0);
    chk("abort_fail_idx", bus.fail_idx, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("post_abort_done", bus.done, 0);
    chk("post_abort_busy", bus.busy, 0);
`ifdef TRUTH_TABLE_FAULT_INJECT_EN
    fmode = 2'd1;
    sweep(0, 1'b0, 1'b0, 2'b00);
    fmode = 2'd2;
    sweep(0, 1'b1, 1'b0, 2'b10);
    fmode = 2'd0;
    sweep(0, 1'b1, 1'b1, 2'b00);
`else
    sweep(0, 1'b0, 1'b1, 2'b00);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
